rv_uart_tx_arb: RTL and testbench
=================================

# rv_uart_tx_arb

Round-robin, message-locked arbiter that shares the single UART transmitter among several byte-stream requesters, such as CPU console output and a hardware status/ebreak reporter. Each requester owns the UART for a whole message, delimited by `last`. A stalled owner is evicted after a programmable idle timeout so the console never wedges. The block sits between the requesters and the UART TX byte interface, feeding it through a one-entry output register.

## Interface
- `NUM_REQ`, default 2: number of requesters; must be ≥ 2.
- `TIMEOUT_CYCLES`, default 1024: owner-idle cycles before forced release; 0 disables the timeout.
- `IDX_W`, derived as `$clog2(NUM_REQ)`: width of the grant index.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `s_valid`  in  NUM_REQ  per-requester byte valid.
- `s_data`  in  NUM_REQ×8  per-requester byte, packed `[NUM_REQ-1:0][7:0]`.
- `s_last`  in  NUM_REQ  byte is the final byte of its message.
- `s_ready`  out  NUM_REQ  per-requester byte accepted.
- `m_valid`  out  1  byte available to the UART TX.
- `m_data`  out  8  byte to the UART TX.
- `m_ready`  in  1  UART TX accepts the byte.
- `grant_valid`  out  1  a requester currently owns the UART.
- `grant_idx`  out  IDX_W  index of the owner; holds the last owner when `grant_valid`=0.

## Operation
- FSM states: IDLE and LOCKED.
- IDLE:
  - If any `s_valid` is high, select the first requester at or after `(last_idx+1) mod NUM_REQ`, wrapping.
  - Register the selection into `grant_idx`, set `grant_valid`=1 and go to LOCKED.
  - No byte is accepted in the IDLE cycle.
- LOCKED:
  - `s_ready[i]` = `grant_valid && grant_idx==i && (!m_valid || m_ready)`. It is combinational and is 0 for every non-owner.
  - Transfer happens when `s_valid[g] && s_ready[g]`. On transfer, `m_data`←`s_data[g]` and `m_valid`←1.
  - `m_valid` clears on `m_ready` when there is no new transfer in the same cycle. A transfer and a drain in the same cycle give back-to-back bytes with no bubble.
- Release of ownership:
  - Release occurs on a transfer with `s_last[g]`=1, or when the timeout fires.
  - On release: `grant_valid`←0, `last_idx`←`grant_idx`, return to IDLE.
  - A byte already held in the output register still drains normally after release.
- Timeout:
  - The counter clears on every owner transfer and on entry to LOCKED.
  - It increments on each LOCKED cycle where `s_valid[g]`=0. Cycles stalled by `m_ready`=0 do not count.
  - At count == `TIMEOUT_CYCLES`-1 with `s_valid[g]` still 0, the arbiter releases.
  - The counter width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates without wrapping.
- Non-owner requests stay pending with no loss. Requesters must hold `s_valid` and data until ready.
- Reset values: state=IDLE, `grant_valid`=0, `grant_idx`=0, `last_idx`=NUM_REQ-1 (so requester 0 wins the first arbitration), `m_valid`=0, `m_data`=0, counter=0.
- Reset asserted mid-message drops the held byte and ownership immediately, asynchronously.

## Timing
- Latency from request to grant: `s_valid` rises in IDLE in cycle N → `grant_valid`=1 in cycle N+1 → first `s_ready` possible in cycle N+1.
- Latency from accept to output: a byte accepted in cycle N is on `m_valid`/`m_data` in cycle N+1.
- Throughput inside a message: 1 byte/cycle while `m_ready`=1.
- Message to message: 1 IDLE cycle of arbitration gap.
- All outputs except `s_ready` are registered. `s_ready` depends on `m_ready` and on registered state only. It never depends on `s_valid`.

## Structure
- Package `rv_uart_arb_pkg` holds the FSM state enum (`ARB_IDLE`, `ARB_LOCKED`) and the byte-width constant (8).
- Sub-module `rv_rr_pick`: combinational round-robin selector.
  - Inputs: request vector and `last_idx`.
  - Outputs: `found` and `idx`.
  - Implemented as a doubled-vector priority scan.
- The FSM, timeout counter and output register live in `rv_uart_tx_arb`.

## Test plan
- Single message: req0 sends 0x48,0x69,last 0x0A with `m_ready`=1 → `m_data` sequence 48,69,0A on consecutive cycles; `grant_valid` drops the cycle after 0x0A is accepted.
- Contention: req0 and req1 assert together from reset with 2-byte messages → req0's message is output complete first, then after 1 IDLE cycle req1's; `grant_idx` goes 0 then 1; no interleaving.
- Round-robin fairness: both requesters continuously request 1-byte messages (NUM_REQ=2) → grants alternate 0,1,0,1 for at least 8 messages.
- Back-pressure: `m_ready`=0 for 5 cycles mid-message → `s_ready`=0, `m_data` stable, no byte lost or duplicated, timeout counter stays 0.
- Timeout: TIMEOUT_CYCLES=4; req1 sends 1 byte without last, then drops `s_valid` → release after 4 idle cycles; pending req0 is granted on the next cycle.
- Reset mid-message: `rst_n` pulled low asynchronously while `m_valid`=1 → `m_valid`, `grant_valid` and `s_ready` go 0 immediately; after release, req0 wins first.

Source files
------------

// File: rtl/rv_uart_arb_pkg.sv
// Shared types and constants for the UART TX requester arbiter.
package rv_uart_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rv_rr_pick.sv
// Combinational round-robin selector: first requester at or after last_idx+1, wrapping.
module rv_rr_pick #(
  parameter int unsigned  NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  localparam int unsigned SH_W = IDX_W + 1;

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] rot;
  logic [SH_W-1:0]      shamt;

  // Doubled vector rotated so bit 0 is the highest-priority candidate.
  always_comb begin
    dbl   = {req, req};
    shamt = {1'b0, last_idx} + SH_W'(1);
    rot   = dbl >> shamt;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(last_idx) + 1 + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/rv_uart_tx_arb.sv
// Message-locked round-robin arbiter sharing one UART TX byte port among requesters,
// with owner-idle eviction and a one-entry output register.
module rv_uart_tx_arb
  import rv_uart_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ        = 2,
  parameter int unsigned  TIMEOUT_CYCLES = 1024,
  localparam int unsigned IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             s_valid,
  input  logic [NUM_REQ-1:0][BYTE_W-1:0] s_data,
  input  logic [NUM_REQ-1:0]             s_last,
  output logic [NUM_REQ-1:0]             s_ready,
  output logic                           m_valid,
  output logic [BYTE_W-1:0]              m_data,
  input  logic                           m_ready,
  output logic                           grant_valid,
  output logic [IDX_W-1:0]               grant_idx
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  arb_state_e        state, state_nxt;
  logic              grant_valid_nxt;
  logic [IDX_W-1:0]  grant_idx_nxt;
  logic [IDX_W-1:0]  last_idx, last_idx_nxt;
  logic              m_valid_nxt;
  logic [BYTE_W-1:0] m_data_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              own_valid;
  logic [BYTE_W-1:0] own_data;
  logic              own_last;
  logic              out_free;
  logic              xfer;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  rv_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req      (s_valid),
    .last_idx (last_idx),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Owner mux and ready; ready never looks at s_valid.
  always_comb begin
    out_free  = !m_valid || m_ready;
    own_valid = 1'b0;
    own_data  = '0;
    own_last  = 1'b0;
    s_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        own_valid  = s_valid[i];
        own_data   = s_data[i];
        own_last   = s_last[i];
        s_ready[i] = grant_valid && out_free;
      end
    end
    xfer = own_valid && grant_valid && out_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      last_idx    <= IDX_W'(NUM_REQ - 1);
      m_valid     <= 1'b0;
      m_data      <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      grant_valid <= grant_valid_nxt;
      grant_idx   <= grant_idx_nxt;
      last_idx    <= last_idx_nxt;
      m_valid     <= m_valid_nxt;
      m_data      <= m_data_nxt;
      cnt         <= cnt_nxt;
    end
  end

  // Next state: arbitration, ownership release, idle timeout and output register.
  always_comb begin
    state_nxt       = state;
    grant_valid_nxt = grant_valid;
    grant_idx_nxt   = grant_idx;
    last_idx_nxt    = last_idx;
    m_valid_nxt     = m_valid && !m_ready;
    m_data_nxt      = m_data;
    cnt_nxt         = cnt;

    if (xfer) begin
      m_valid_nxt = 1'b1;
      m_data_nxt  = own_data;
    end

    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_nxt       = ARB_LOCKED;
          grant_valid_nxt = 1'b1;
          grant_idx_nxt   = pick_idx;
          cnt_nxt         = '0;
        end
      end
      ARB_LOCKED: begin
        if (xfer) begin
          cnt_nxt = '0;
          if (own_last) begin
            state_nxt       = ARB_IDLE;
            grant_valid_nxt = 1'b0;
            last_idx_nxt    = grant_idx;
          end
        end else if (!own_valid) begin
          if (TO_EN && (cnt == CNT_FIRE)) begin
            state_nxt       = ARB_IDLE;
            grant_valid_nxt = 1'b0;
            last_idx_nxt    = grant_idx;
          end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt       = ARB_IDLE;
        grant_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rv_uart_tx_arb.sv
// Self-checking bench for rv_uart_tx_arb: directed scenarios plus a randomized
// message-stream scoreboard with round-robin and no-interleave checks.
module tb_rv_uart_tx_arb;

  logic            clk;
  logic            rst_n;
  logic [1:0]      s_valid;
  logic [1:0][7:0] s_data;
  logic [1:0]      s_last;
  logic [1:0]      s_ready;
  logic            m_valid;
  logic [7:0]      m_data;
  logic            m_ready;
  logic            grant_valid;
  logic [0:0]      grant_idx;

  rv_uart_tx_arb #(.NUM_REQ(2), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-requester byte streams and driver state.
  logic [7:0] q_data [2][$];
  bit         q_last [2][$];
  int         ptr [2];
  int         gap [2];
  bit         rand_gap, mr_rand, mr_next;

  // Snapshot taken at the negative edge.
  bit              o_gv, o_mv, o_fire;
  int              o_gidx;
  logic [7:0]      o_md;
  logic [1:0]      o_srdy, o_acc, o_valid, o_last;
  logic [1:0][7:0] o_sd;

  task automatic push_msg(input int r, input logic [7:0] d, input bit l);
    q_data[r].push_back(d);
    q_last[r].push_back(l);
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < 2; r++) begin
      if (ptr[r] < q_data[r].size() && gap[r] == 0) begin
        s_valid[r] = 1'b1; s_data[r] = q_data[r][ptr[r]]; s_last[r] = q_last[r][ptr[r]];
      end else begin
        s_valid[r] = 1'b0; s_data[r] = 8'h00; s_last[r] = 1'b0;
      end
    end
  endtask

  task automatic capture();
    o_gv = grant_valid; o_gidx = int'(grant_idx); o_mv = m_valid; o_md = m_data;
    o_srdy = s_ready; o_valid = s_valid; o_last = s_last; o_sd = s_data;
    o_acc = s_valid & s_ready; o_fire = m_valid & m_ready;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      if (o_acc[r]) begin
        ptr[r]++;
        gap[r] = rand_gap ? int'($urandom_range(0, 2)) : 0;
      end else if (gap[r] > 0) gap[r]--;
    end
    m_ready = mr_rand ? ($urandom_range(0, 3) != 0) : mr_next;
    drive_inputs();
    @(negedge clk);
    capture();
  endtask

  task automatic start();
    m_ready = mr_next;
    drive_inputs();
    #1 capture();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rand_gap = 1'b0; mr_rand = 1'b0; mr_next = 1'b1;
    for (int r = 0; r < 2; r++) begin
      q_data[r].delete(); q_last[r].delete(); ptr[r] = 0; gap[r] = 0;
    end
    s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b0; o_acc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL reset_grant_valid got=%b exp=0", grant_valid); end
    n_cmp++; if (grant_idx !== 1'b0) begin n_bad++; $display("FAIL reset_grant_idx got=%b exp=0", grant_idx); end
    n_cmp++; if (s_ready !== 2'b00) begin n_bad++; $display("FAIL reset_s_ready got=%b exp=00", s_ready); end
  endtask

  task automatic test_single_message();
    bit         emv [6] = '{0, 0, 1, 1, 1, 0};
    logic [7:0] emd [6] = '{8'h00, 8'h00, 8'h48, 8'h69, 8'h0A, 8'h00};
    bit         egv [6] = '{0, 1, 1, 1, 0, 0};
    do_reset();
    push_msg(0, 8'h48, 0); push_msg(0, 8'h69, 0); push_msg(0, 8'h0A, 1);
    start();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      n_cmp++; if (o_mv !== emv[c]) begin n_bad++; $display("FAIL single_mv c%0d got=%b exp=%b", c, o_mv, emv[c]); end
      if (emv[c]) begin
        n_cmp++; if (o_md !== emd[c]) begin n_bad++; $display("FAIL single_md c%0d got=%h exp=%h", c, o_md, emd[c]); end
      end
      n_cmp++; if (o_gv !== egv[c]) begin n_bad++; $display("FAIL single_gv c%0d got=%b exp=%b", c, o_gv, egv[c]); end
    end
  endtask

  task automatic test_contention();
    bit         emv [7] = '{0, 0, 1, 1, 0, 1, 1};
    logic [7:0] emd [7] = '{8'h00, 8'h00, 8'hA0, 8'hA1, 8'h00, 8'hB0, 8'hB1};
    bit         egv [7] = '{0, 1, 1, 0, 1, 1, 0};
    int         egi [7] = '{0, 0, 0, 0, 1, 1, 1};
    do_reset();
    push_msg(0, 8'hA0, 0); push_msg(0, 8'hA1, 1);
    push_msg(1, 8'hB0, 0); push_msg(1, 8'hB1, 1);
    start();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      n_cmp++; if (o_mv !== emv[c]) begin n_bad++; $display("FAIL contend_mv c%0d got=%b exp=%b", c, o_mv, emv[c]); end
      if (emv[c]) begin
        n_cmp++; if (o_md !== emd[c]) begin n_bad++; $display("FAIL contend_md c%0d got=%h exp=%h", c, o_md, emd[c]); end
      end
      n_cmp++; if (o_gv !== egv[c] || o_gidx != egi[c]) begin
        n_bad++; $display("FAIL contend_grant c%0d got=%b/%0d exp=%b/%0d", c, o_gv, o_gidx, egv[c], egi[c]);
      end
    end
  endtask

  task automatic test_round_robin();
    int ng = 0, no = 0;
    bit pgv;
    logic [7:0] exp_b;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      push_msg(0, 8'($urandom), 1);
      push_msg(1, 8'($urandom), 1);
    end
    start();
    pgv = o_gv;
    for (int c = 0; c < 80 && (ng < 16 || no < 16); c++) begin
      tick();
      if (o_gv && !pgv) begin
        n_cmp++; if (o_gidx != ng % 2) begin n_bad++; $display("FAIL rr_grant #%0d got=%0d exp=%0d", ng, o_gidx, ng % 2); end
        ng++;
      end
      if (o_fire && no < 16) begin
        exp_b = q_data[no % 2][no / 2];
        n_cmp++; if (o_md !== exp_b) begin n_bad++; $display("FAIL rr_byte #%0d got=%h exp=%h", no, o_md, exp_b); end
        no++;
      end
      pgv = o_gv;
    end
    n_cmp++; if (ng != 16 || no != 16) begin n_bad++; $display("FAIL rr_count got=%0d/%0d exp=16/16", ng, no); end
  endtask

  task automatic test_backpressure();
    bit         emr [12] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    bit         emv [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] emd [12] = '{8'h00, 8'h00, 8'hE0, 8'hE1, 8'hE1, 8'hE1, 8'hE1, 8'hE1, 8'hE1, 8'hE2, 8'hE3, 8'h00};
    bit         egv [12] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [1:0] esr [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    do_reset();
    push_msg(0, 8'hE0, 0); push_msg(0, 8'hE1, 0); push_msg(0, 8'hE2, 0); push_msg(0, 8'hE3, 1);
    mr_next = emr[0];
    start();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin mr_next = emr[c]; tick(); end
      n_cmp++; if (o_mv !== emv[c]) begin n_bad++; $display("FAIL bp_mv c%0d got=%b exp=%b", c, o_mv, emv[c]); end
      if (emv[c]) begin
        n_cmp++; if (o_md !== emd[c]) begin n_bad++; $display("FAIL bp_md c%0d got=%h exp=%h", c, o_md, emd[c]); end
      end
      n_cmp++; if (o_gv !== egv[c]) begin n_bad++; $display("FAIL bp_gv c%0d got=%b exp=%b", c, o_gv, egv[c]); end
      n_cmp++; if (o_srdy !== esr[c]) begin n_bad++; $display("FAIL bp_srdy c%0d got=%b exp=%b", c, o_srdy, esr[c]); end
    end
  endtask

  task automatic test_timeout();
    bit         emv [9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
    logic [7:0] emd [9] = '{8'h00, 8'h00, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hD0};
    bit         egv [9] = '{0, 1, 1, 1, 1, 1, 0, 1, 0};
    int         egi [9] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [1:0] esr [9] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
    do_reset();
    push_msg(1, 8'hC0, 0);
    start();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      n_cmp++; if (o_mv !== emv[c]) begin n_bad++; $display("FAIL to_mv c%0d got=%b exp=%b", c, o_mv, emv[c]); end
      if (emv[c]) begin
        n_cmp++; if (o_md !== emd[c]) begin n_bad++; $display("FAIL to_md c%0d got=%h exp=%h", c, o_md, emd[c]); end
      end
      n_cmp++; if (o_gv !== egv[c] || o_gidx != egi[c]) begin
        n_bad++; $display("FAIL to_grant c%0d got=%b/%0d exp=%b/%0d", c, o_gv, o_gidx, egv[c], egi[c]);
      end
      n_cmp++; if (o_srdy !== esr[c]) begin n_bad++; $display("FAIL to_srdy c%0d got=%b exp=%b", c, o_srdy, esr[c]); end
      if (c == 1) push_msg(0, 8'hD0, 1);
    end
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    push_msg(0, 8'hF0, 0); push_msg(0, 8'hF1, 0); push_msg(0, 8'hF2, 1);
    start();
    tick(); tick();
    n_cmp++; if (o_mv !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_mv got=%b exp=1", o_mv); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_m_valid got=%b exp=0", m_valid); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_grant_valid got=%b exp=0", grant_valid); end
    n_cmp++; if (s_ready !== 2'b00) begin n_bad++; $display("FAIL rstmid_s_ready got=%b exp=00", s_ready); end
    for (int r = 0; r < 2; r++) begin
      q_data[r].delete(); q_last[r].delete(); ptr[r] = 0; gap[r] = 0;
    end
    push_msg(0, 8'h11, 1); push_msg(1, 8'h22, 1);
    o_acc = '0;
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    start();
    tick();
    n_cmp++; if (o_gv !== 1'b1 || o_gidx != 0) begin
      n_bad++; $display("FAIL rstmid_first_grant got=%b/%0d exp=1/0", o_gv, o_gidx);
    end
  endtask

  task automatic test_random_streams();
    logic [7:0] exp_out [$];
    logic [7:0] exp_b;
    int         owner = -1;
    int         exp_last = 1;
    int         exp_g;
    bit         pgv;
    logic [1:0] pvalid;
    bit         done = 1'b0;
    do_reset();
    rand_gap = 1'b1; mr_rand = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int m = 0; m < 12; m++) begin
        int len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) push_msg(r, 8'($urandom), b == len - 1);
      end
    end
    start();
    pgv = o_gv; pvalid = o_valid;
    for (int c = 0; c < 3000 && !done; c++) begin
      tick();
      if (o_fire) begin
        n_cmp++;
        if (exp_out.size() == 0) begin n_bad++; $display("FAIL rand_extra_byte got=%h exp=none", o_md); end
        else begin
          exp_b = exp_out.pop_front();
          if (o_md !== exp_b) begin n_bad++; $display("FAIL rand_byte got=%h exp=%h", o_md, exp_b); end
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (o_acc[r]) begin
          n_cmp++; if (owner >= 0 && owner != r) begin
            n_bad++; $display("FAIL rand_interleave got=req%0d exp=req%0d", r, owner);
          end
          exp_out.push_back(o_sd[r]);
          owner = o_last[r] ? -1 : r;
        end
      end
      n_cmp++; if ($countones(o_srdy) > 1) begin n_bad++; $display("FAIL rand_srdy_onehot got=%b exp=onehot0", o_srdy); end
      if (o_gv && !pgv) begin
        exp_g = pvalid[(exp_last + 1) % 2] ? (exp_last + 1) % 2 : exp_last;
        n_cmp++; if (o_gidx != exp_g) begin n_bad++; $display("FAIL rand_rr got=%0d exp=%0d", o_gidx, exp_g); end
        exp_last = exp_g;
      end
      pgv = o_gv; pvalid = o_valid;
      done = (ptr[0] >= q_data[0].size()) && (ptr[1] >= q_data[1].size()) && (exp_out.size() == 0);
    end
    n_cmp++; if (!done) begin
      n_bad++; $display("FAIL rand_complete got=%0d/%0d pending=%0d exp=%0d/%0d pending=0",
                        ptr[0], ptr[1], exp_out.size(), q_data[0].size(), q_data[1].size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_message();
    test_contention();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_message();
    test_random_streams();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
